// File: rtl/alu_seq_param_pkg.sv
// Shared encodings for the parametrised sequential ALU: opcodes, FSM states, flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_CMP = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_DZ    = 3;
  localparam int NUM_FLAGS  = 4;

endpackage

// File: rtl/alu_seq_param_if.sv
// Host-side bus of the sequential ALU, grouped so the host and the ALU connect through one port.
interface alu_seq_param_if #(parameter int WIDTH = 8);

  // Handshake: start is sampled only while busy=0 (including the done cycle); an accepted
  // start raises busy on the following cycle; done pulses for one cycle on completion, and
  // result/flags are valid from that cycle and held until the next completion.
  logic                 start;
  logic [2:0]           op;
  logic                 op_signed;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 flag_zero;
  logic                 flag_carry;
  logic                 flag_ovf;
  logic                 flag_dz;

  modport master (
    output start, op, op_signed, in_a, in_b,
    input  busy, done, result, flag_zero, flag_carry, flag_ovf, flag_dz
  );

  modport slave (
    input  start, op, op_signed, in_a, in_b,
    output busy, done, result, flag_zero, flag_carry, flag_ovf, flag_dz
  );

endinterface

// File: rtl/alu_seq_param_iter_unit.sv
// Iterative magnitude datapath: shift-add multiply and restoring divide, one step per cycle.
module alu_iter_unit #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 iterate_i,
  input  logic                 is_div_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   product_o,
  output logic [WIDTH-1:0]     quotient_o,
  output logic [WIDTH-1:0]     remainder_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  logic [2*WIDTH-1:0] acc_q, acc_d, step;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH:0]     mul_sum, shifted, trial;

  always_comb begin
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    shifted = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    trial   = shifted - {1'b0, b_q};
    if (is_div_q) begin
      if (!trial[WIDTH]) step = {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else               step = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    acc_d    = acc_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    if (load_i) begin
      acc_d    = {{WIDTH{1'b0}}, a_i};
      b_d      = b_i;
      cnt_d    = '0;
      is_div_d = is_div_i;
    end else if (iterate_i) begin
      acc_d = step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  // Outputs show the value after the current step so the final edge can capture it directly.
  assign last_o      = iterate_i && (cnt_q == CW'(WIDTH - 1));
  assign product_o   = step;
  assign quotient_o  = step[WIDTH-1:0];
  assign remainder_o = step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq_param.sv
// Parametrised multi-cycle ALU: busy/done handshake FSM, sign handling, single-cycle ops, flags.
module alu_seq_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  alu_seq_param_if.slave   bus,
  output state_e           dbg_state_o
);

  state_e               state_q, state_d;
  logic [2:0]           op_q;
  logic                 sgn_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   result_q;
  logic [NUM_FLAGS-1:0] flags_q;

  logic accept, iter_op, iterate, complete, iter_last;
  logic [2*WIDTH-1:0] mul_p;
  logic [WIDTH-1:0]   quo_p, rem_p;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? -v : v;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (complete)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    accept   = (state_q == IDLE) && bus.start;
    iter_op  = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));
    iterate  = (state_q == RUN) && iter_op;
    complete = (state_q == RUN) && (!iter_op || iter_last);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= '0;
      sgn_q <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      sgn_q <= bus.op_signed;
      a_q   <= bus.in_a;
      b_q   <= bus.in_b;
    end
  end

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .iterate_i   (iterate),
    .is_div_i    (bus.op == OP_DIV),
    .a_i         (mag(bus.in_a, bus.op_signed)),
    .b_i         (mag(bus.in_b, bus.op_signed)),
    .last_o      (iter_last),
    .product_o   (mul_p),
    .quotient_o  (quo_p),
    .remainder_o (rem_p)
  );

  logic [WIDTH:0]       sum_u, sum_s, diff;
  logic                 add_ovf, sub_ovf, div_ovf;
  logic [2*WIDTH-1:0]   prod_s;
  logic [WIDTH-1:0]     quo_s, rem_s;
  logic [2*WIDTH-1:0]   res_d;
  logic [NUM_FLAGS-1:0] flags_d;

  always_comb begin
    sum_u   = {1'b0, a_q} + {1'b0, b_q};
    sum_s   = {a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q};
    diff    = {1'b0, a_q} - {1'b0, b_q};
    add_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_u[WIDTH-1] != a_q[WIDTH-1]);
    sub_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    // Magnitude results get their sign back here; remainder follows the dividend.
    prod_s  = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -mul_p : mul_p;
    quo_s   = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_p : quo_p;
    rem_s   = (sgn_q && a_q[WIDTH-1]) ? -rem_p : rem_p;
    div_ovf = sgn_q && (a_q == {1'b1, {(WIDTH-1){1'b0}}}) && (b_q == '1);
  end

  always_comb begin
    res_d   = '0;
    flags_d = '0;
    case (op_q)
      OP_ADD: begin
        res_d = sgn_q ? {{(WIDTH-1){sum_s[WIDTH]}}, sum_s} : {{(WIDTH-1){1'b0}}, sum_u};
        flags_d[FLAG_CARRY] = sum_u[WIDTH];
        flags_d[FLAG_OVF]   = sgn_q & add_ovf;
      end
      OP_SUB: begin
        res_d = {{WIDTH{sgn_q & diff[WIDTH-1]}}, diff[WIDTH-1:0]};
        flags_d[FLAG_CARRY] = diff[WIDTH];
        flags_d[FLAG_OVF]   = sgn_q & sub_ovf;
      end
      OP_CMP: begin
        flags_d[FLAG_CARRY] = diff[WIDTH];
        flags_d[FLAG_OVF]   = sgn_q & sub_ovf;
      end
      OP_MUL: begin
        res_d = prod_s;
        flags_d[FLAG_OVF] = sgn_q ? ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]))
                                  : (|prod_s[2*WIDTH-1:WIDTH]);
      end
      OP_DIV: begin
        if (b_q == '0) begin
          res_d = {a_q, {WIDTH{1'b1}}};
          flags_d[FLAG_DZ] = 1'b1;
        end else begin
          res_d = {rem_s, quo_s};
          flags_d[FLAG_OVF] = div_ovf;
        end
      end
      OP_AND:  res_d = {{WIDTH{1'b0}}, a_q & b_q};
      OP_OR:   res_d = {{WIDTH{1'b0}}, a_q | b_q};
      OP_XOR:  res_d = {{WIDTH{1'b0}}, a_q ^ b_q};
      default: res_d = '0;
    endcase
    flags_d[FLAG_ZERO] = (op_q == OP_CMP) ? (a_q == b_q) : (res_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q   <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      done_q <= complete;
      if (complete) begin
        result_q <= res_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign bus.busy       = (state_q == RUN);
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.flag_zero  = flags_q[FLAG_ZERO];
  assign bus.flag_carry = flags_q[FLAG_CARRY];
  assign bus.flag_ovf   = flags_q[FLAG_OVF];
  assign bus.flag_dz    = flags_q[FLAG_DZ];
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_alu_seq_param.sv
// Randomised and directed bench for alu_seq_param against an arithmetic reference model.
module tb_alu_seq_param;
  import alu_pkg::*;

  localparam int W = 8;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_seq_param_if #(.WIDTH(W)) bus();
  state_e dbg_state;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [2*W+3:0] exp_q[$];  // {dz, ovf, carry, zero, result}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic out_rng(input longint x);
    longint half;
    half = longint'(1) << (W - 1);
    return (x < -half) || (x > half - 1);
  endfunction

  // Reference model: plain integer arithmetic on the operand values.
  function automatic void model(input logic [2:0] op, input logic sgn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [2*W-1:0] res, output logic [3:0] flags,
                                output int lat);
    longint ua, ub, sa, sb, v, lo, q, r, mask, half;
    logic signed [W-1:0] as_v, bs_v;
    logic z, c, o, d;
    mask = (longint'(1) << W) - 1;
    half = longint'(1) << (W - 1);
    as_v = a;
    bs_v = b;
    ua = longint'(a);
    ub = longint'(b);
    sa = sgn ? longint'(as_v) : ua;
    sb = sgn ? longint'(bs_v) : ub;
    lat = 1; c = 0; o = 0; d = 0; v = 0;
    case (op)
      OP_ADD: begin
        v = sa + sb;
        c = ((ua + ub) >> W) != 0;
        if (sgn) o = out_rng(v);
      end
      OP_SUB, OP_CMP: begin
        v  = sa - sb;
        lo = v & mask;
        if (sgn) o = out_rng(v);
        c = ua < ub;
        v = (sgn && lo >= half) ? lo - (mask + 1) : lo;
        if (op == OP_CMP) v = 0;
      end
      OP_MUL: begin
        lat = W;
        v = sa * sb;
        o = sgn ? out_rng(v) : (v > mask);
      end
      OP_DIV: begin
        if (ub == 0) begin
          v = (ua << W) | mask;
          d = 1;
        end else begin
          lat = W;
          q = sa / sb;
          r = sa % sb;
          o = sgn && (sa == -half) && (sb == -1);
          v = ((r & mask) << W) | (q & mask);
        end
      end
      OP_AND:  v = ua & ub;
      OP_OR:   v = ua | ub;
      default: v = ua ^ ub;
    endcase
    res = v[2*W-1:0];
    z = (op == OP_CMP) ? (ua == ub) : (res == '0);
    flags = {d, o, c, z};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.flag_dz, bus.flag_ovf, bus.flag_carry, bus.flag_zero};
  endfunction

  // Driver: called at a negedge with the DUT idle or in its done cycle; returns at the done negedge.
  task automatic run_op(input logic [2:0] op, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic poke);
    logic [2*W-1:0] er;
    logic [3:0] ef;
    logic [2*W+3:0] e;
    int lat, cyc;
    model(op, sgn, a, b, er, ef, lat);
    exp_q.push_back({ef, er});
    bus.start = 1'b1; bus.op = op; bus.op_signed = sgn; bus.in_a = a; bus.in_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_after_accept", 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 3 * W) begin
      if (poke && cyc == 2) begin
        bus.start = 1'b1;
        bus.op = 3'($urandom_range(0, 7));
        bus.in_a = W'($urandom);
        bus.in_b = W'($urandom);
      end
      @(negedge clk);
      cyc++;
      bus.start = 1'b0;
      if (!bus.done) check("busy_while_running", 32'(bus.busy), 32'd1);
    end
    bus.start = 1'b0;
    check("latency", 32'(cyc), 32'(lat));
    check("done_seen", 32'(bus.done), 32'd1);
    check("busy_at_done", 32'(bus.busy), 32'd0);
    e = exp_q.pop_front();
    check("result", 32'(bus.result), 32'(e[2*W-1:0]));
    check("flags", 32'(dut_flags()), 32'(e[2*W+3:2*W]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2*W-1:0] held;
    logic [2:0] rop;
    logic [W-1:0] ra, rb;
    int seen;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.op_signed = 1'b0; bus.in_a = '0; bus.in_b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_flags", 32'(dut_flags()), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op(OP_ADD, 1'b0, 8'd25, 8'd17, 1'b0);
    run_op(OP_ADD, 1'b0, 8'd200, 8'd100, 1'b0);
    run_op(OP_MUL, 1'b0, 8'd6, 8'd9, 1'b0);
    run_op(OP_MUL, 1'b1, 8'hFD, 8'd5, 1'b0);
    run_op(OP_DIV, 1'b0, 8'd100, 8'd7, 1'b0);
    run_op(OP_DIV, 1'b1, 8'hF9, 8'd2, 1'b0);
    run_op(OP_DIV, 1'b0, 8'd10, 8'd0, 1'b0);
    run_op(OP_DIV, 1'b1, 8'h80, 8'hFF, 1'b0);
    run_op(OP_CMP, 1'b0, 8'd42, 8'd42, 1'b0);
    run_op(OP_SUB, 1'b1, 8'h80, 8'd1, 1'b0);
    run_op(OP_MUL, 1'b1, 8'h80, 8'h80, 1'b0);

    // Start pulsed mid-operation must be ignored; no extra completion afterwards
    run_op(OP_MUL, 1'b0, 8'd7, 8'd11, 1'b1);
    held = bus.result;
    seen = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("no_ghost_done", 32'(seen), 32'd0);
    check("result_held", 32'(bus.result), 32'(held));
    run_op(OP_ADD, 1'b0, 8'd3, 8'd4, 1'b0);
    @(negedge clk);

    // Reset at edge N+4 of a multiply aborts it
    bus.start = 1'b1; bus.op = OP_MUL; bus.op_signed = 1'b0; bus.in_a = 8'd6; bus.in_b = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    check("abort_flags", 32'(dut_flags()), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (W + 2) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(OP_ADD, 1'b0, 8'd1, 8'd1, 1'b0);

    // Randomised operations, back-to-back or with idle gaps
    repeat (250) begin
      rop = 3'($urandom_range(0, 7));
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 8'h80; rb = 8'hFF; end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
      run_op(rop, 1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_param.md
Name: alu_seq_param

Overview:
- Parametrised, multi-cycle successor to the 8-bit sequential ALU (`alu_top`).
- Operand width is set by parameter.
- Multiply and divide are iterative and take one iteration per cycle.
- Adds signed mode, a remainder output, status flags, and a busy/done handshake.
- Sits behind a register-file or host interface; one operation is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits (min 4); result is 2*WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 CMP.
- op_signed  in  1  two's-complement interpretation for ADD/SUB/MUL/DIV/CMP.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- busy  out  1  operation accepted and not finished.
- done  out  1  one-cycle pulse; result/flags valid from this cycle.
- result  out  2*WIDTH  registered result, held until the next completion.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  ADD carry-out / SUB,CMP borrow (unsigned).
- flag_ovf  out  1  signed overflow, or MUL product not representable in WIDTH bits.
- flag_dz  out  1  divide by zero.

Behaviour:
- Reset: state IDLE; busy=0, done=0, result=0, all flags 0; iteration counter and operand registers cleared.
- Reset mid-operation: aborts the operation; no done pulse; outputs return to their reset values.
- States:
  - IDLE: start=1 at edge N latches op, op_signed, in_a, in_b; goes to RUN; busy=1 after edge N.
  - RUN: single-cycle ops (ADD/SUB/AND/OR/XOR/CMP, and DIV with in_b==0) complete at edge N+1.
  - RUN: MUL/DIV perform WIDTH iterations (edges N+1..N+WIDTH) and complete at edge N+WIDTH.
  - Completion edge: result and flags are registered, done=1 for exactly one cycle, busy=0, state returns to IDLE.
- start while busy=1: ignored, with no effect on the operation in flight.
- start during the done cycle: accepted; a back-to-back operation is legal.
- ADD:
  - Unsigned: result = zero-extended WIDTH+1-bit sum; carry = bit WIDTH.
  - Signed: result = sign-extended WIDTH+1-bit sum; ovf = signed overflow of the WIDTH-bit sum.
- SUB: result[W-1:0] = A-B mod 2^W; upper half zero (unsigned) or sign-extension (signed); carry = borrow (A<B unsigned); ovf as for ADD.
- CMP: same as SUB, but result is forced to 0; only the flags update (zero = A==B).
- AND/OR/XOR: bitwise on WIDTH bits; upper half zero; carry=ovf=0.
- MUL:
  - Shift-add over the magnitudes; sign fixed at the end when signed.
  - result = full 2*WIDTH product.
  - ovf=1 if the product does not fit WIDTH bits (signed or unsigned range per op_signed).
- DIV:
  - Restoring division over the magnitudes.
  - result = {remainder[W-1:0], quotient[W-1:0]}.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
  - Signed -2^(W-1) / -1: quotient = -2^(W-1), remainder 0, ovf=1.
- DIV by zero: 1-cycle latency; quotient = all ones, remainder = in_a; dz=1; ovf=0.
- flag_zero is computed on the final result for all ops except CMP (see above).
- flag_dz is 0 for every op other than DIV.
- All flags are registered with result and held until the next completion.

Decomposition:
- Package alu_pkg:
  - op encoding localparams (OP_ADD..OP_CMP);
  - state enum (IDLE, RUN);
  - flag index constants.
- Sub-module alu_iter_unit(WIDTH): shift-add multiply / restoring divide datapath.
  - Interface: load, iterate, last-iteration indication.
  - Outputs: product, quotient, remainder.
- Top level: handshake FSM, sign handling, single-cycle ops, flag generation.

Test Plan (WIDTH=8):
- ADD 25+17, then ADD 200+100 -> 16'd42, done at N+1; then 16'd300, carry=1, zero=0.
- MUL unsigned 6*9 -> 16'd54, done exactly at N+8, busy high N+1..N+8. Signed -3*5 -> 16'hFFF1, ovf=0.
- DIV 100/7 -> 16'h020E (r=2, q=14). Signed -7/2 -> q=8'hFD, r=8'hFF.
- DIV 10/0 -> 16'h0AFF, dz=1, done at N+1.
- Signed -128/-1 -> q=8'h80, ovf=1.
- CMP 42 vs 42 -> result 0, zero=1, carry=0.
- Then pulse start with MUL during busy -> ignored; the second op completes with its own values only after a new start.
- Reset asserted at N+4 of MUL -> no done pulse; result=0, busy=0 the next cycle.
- Then ADD 1+1 -> 16'd2, normal completion.
